rf_scoreboard: RTL and testbench

//  Scoreboard and hazard controller for reg_file in the MIPS pipeline.
//  - Tracks outstanding writes to each architectural register between ID issue and WB.
//  - Stalls ID when a source operand, or the destination write slot, is not safe.
//  - Sits beside reg_file: ID drives issue fields, WB drives the write-back notification.

---
 rtl/rf_scoreboard.sv | 119 +++++++++++
 tb/tb_rf_scoreboard.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/rf_scoreboard.sv
// Scoreboard and hazard controller for reg_file: tracks outstanding writes per register and stalls ID on hazards.
// Optional WB-cycle source bypass enabled by defining RF_SB_WB_BYPASS_EN.
module rf_scoreboard #(
  parameter int RF_REG_W   = 5,
  parameter int RF_REG_NUM = 32,
  parameter int CNT_W      = 2,
  parameter int MAX_INFL   = 4,
  parameter int INF_W      = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                iIssueVld,
  input  logic [RF_REG_W-1:0] iRs,
  input  logic                iRsVld,
  input  logic [RF_REG_W-1:0] iRt,
  input  logic                iRtVld,
  input  logic [RF_REG_W-1:0] iRd,
  input  logic                iRdVld,
  input  logic                iWbVld,
  input  logic [RF_REG_W-1:0] iWbReg,
  output logic                oStall,
  output logic                oIssueAck,
  output logic                oFwd1,
  output logic                oFwd2,
  output logic [INF_W-1:0]    oInflight,
  output logic                oErr
);

  logic [CNT_W-1:0] cnt [RF_REG_NUM];
  logic [INF_W-1:0] total;

  logic [CNT_W-1:0] cntRs, cntRt, cntRd, cntWb;
  logic             bypS, bypT;
  logic             hs, ht, hd, hf;
  logic             wbNonZero, wbDec, wbErr, issueInc;

  always_comb begin
    cntRs = cnt[iRs];
    cntRt = cnt[iRt];
    cntRd = cnt[iRd];
    cntWb = cnt[iWbReg];
  end

  always_comb begin
    bypS = 1'b0;
    bypT = 1'b0;
`ifdef RF_SB_WB_BYPASS_EN
    // Last outstanding write is landing this cycle; its data can be forwarded.
    bypS = iWbVld & (iWbReg == iRs) & (cntRs == CNT_W'(1));
    bypT = iWbVld & (iWbReg == iRt) & (cntRt == CNT_W'(1));
`endif
  end

  always_comb begin
    wbNonZero = iWbVld & (iWbReg != '0);
    wbDec     = wbNonZero & (cntWb != '0);
    wbErr     = wbNonZero & (cntWb == '0);

    hs = iRsVld & (iRs != '0) & (cntRs != '0) & ~bypS;
    ht = iRtVld & (iRt != '0) & (cntRt != '0) & ~bypT;
    hd = iRdVld & (iRd != '0) & (cntRd == '1);
    hf = iRdVld & (iRd != '0) & (total == INF_W'(MAX_INFL)) & ~wbDec;

    oStall    = reset | (iIssueVld & (hs | ht | hd | hf));
    oIssueAck = iIssueVld & ~oStall;
    issueInc  = oIssueAck & iRdVld & (iRd != '0);
  end

  // Issue and WB to the same register cancel; cnt[0] is never incremented.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < RF_REG_NUM; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      for (int unsigned r = 1; r < RF_REG_NUM; r++) begin
        if ((issueInc && iRd == RF_REG_W'(r)) && !(wbDec && iWbReg == RF_REG_W'(r))) begin
          cnt[r] <= cnt[r] + CNT_W'(1);
        end else if (!(issueInc && iRd == RF_REG_W'(r)) && (wbDec && iWbReg == RF_REG_W'(r))) begin
          cnt[r] <= cnt[r] - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      total <= '0;
      oErr  <= 1'b0;
    end else begin
      if (issueInc && !wbDec) begin
        total <= total + INF_W'(1);
      end else if (!issueInc && wbDec) begin
        total <= total - INF_W'(1);
      end
      if (wbErr) begin
        oErr <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      oFwd1 <= 1'b0;
      oFwd2 <= 1'b0;
    end else begin
`ifdef RF_SB_WB_BYPASS_EN
      oFwd1 <= oIssueAck & iRsVld & bypS;
      oFwd2 <= oIssueAck & iRtVld & bypT;
`else
      oFwd1 <= 1'b0;
      oFwd2 <= 1'b0;
`endif
    end
  end

  assign oInflight = total;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed table-driven bench for rf_scoreboard; expectations follow RF_SB_WB_BYPASS_EN when defined.
module tb_rf_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       iIssueVld;
  logic [4:0] iRs, iRt, iRd, iWbReg;
  logic       iRsVld, iRtVld, iRdVld, iWbVld;
  logic       oStall, oIssueAck, oFwd1, oFwd2, oErr;
  logic [2:0] oInflight;

  int total = 0;
  int bad   = 0;

`ifdef RF_SB_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always #5 clk = ~clk;

  rf_scoreboard #(
    .RF_REG_W  (5),
    .RF_REG_NUM(32),
    .CNT_W     (2),
    .MAX_INFL  (4),
    .INF_W     (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .iIssueVld(iIssueVld),
    .iRs      (iRs),
    .iRsVld   (iRsVld),
    .iRt      (iRt),
    .iRtVld   (iRtVld),
    .iRd      (iRd),
    .iRdVld   (iRdVld),
    .iWbVld   (iWbVld),
    .iWbReg   (iWbReg),
    .oStall   (oStall),
    .oIssueAck(oIssueAck),
    .oFwd1    (oFwd1),
    .oFwd2    (oFwd2),
    .oInflight(oInflight),
    .oErr     (oErr)
  );

  typedef struct {
    logic       rst;
    logic       iv;
    logic [4:0] rs;
    logic       rsv;
    logic [4:0] rt;
    logic       rtv;
    logic [4:0] rd;
    logic       rdv;
    logic       wv;
    logic [4:0] wr;
    logic       eStall;
    logic       eAck;
    logic [2:0] eInfl;
    logic       eErr;
    logic       eFwd1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic iv,
                              input logic [4:0] rs, input logic rsv,
                              input logic [4:0] rt, input logic rtv,
                              input logic [4:0] rd, input logic rdv,
                              input logic wv, input logic [4:0] wr,
                              input logic eS, input logic eA, input logic [2:0] eI,
                              input logic eE, input logic eF1);
    vec_t v;
    v.rst = rst; v.iv = iv; v.rs = rs; v.rsv = rsv; v.rt = rt; v.rtv = rtv;
    v.rd = rd; v.rdv = rdv; v.wv = wv; v.wr = wr;
    v.eStall = eS; v.eAck = eA; v.eInfl = eI; v.eErr = eE; v.eFwd1 = eF1;
    return v;
  endfunction

  task automatic chk(input string name, input int step, input logic [2:0] act, input logic [2:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, step, act, exp);
    end
  endtask

  // Drive mid-cycle, check combinational outputs before the edge, registered ones after.
  task automatic apply(input vec_t v, input int step);
    @(negedge clk);
    reset = v.rst; iIssueVld = v.iv;
    iRs = v.rs; iRsVld = v.rsv; iRt = v.rt; iRtVld = v.rtv;
    iRd = v.rd; iRdVld = v.rdv; iWbVld = v.wv; iWbReg = v.wr;
    #1;
    chk("stall", step, {2'b0, oStall}, {2'b0, v.eStall});
    chk("ack", step, {2'b0, oIssueAck}, {2'b0, v.eAck});
    @(posedge clk);
    #1;
    chk("inflight", step, oInflight, v.eInfl);
    chk("err", step, {2'b0, oErr}, {2'b0, v.eErr});
    chk("fwd1", step, {2'b0, oFwd1}, {2'b0, v.eFwd1});
    chk("fwd2", step, {2'b0, oFwd2}, 3'd0);
  endtask

  initial begin
    reset = 1'b1; iIssueVld = 1'b0;
    iRs = '0; iRsVld = 1'b0; iRt = '0; iRtVld = 1'b0;
    iRd = '0; iRdVld = 1'b0; iWbVld = 1'b0; iWbReg = '0;

    // reset held with an issue pending
    tbl.push_back(mk(1,1, 0,0, 0,0, 5,1, 0,0,  1,0,0,0,0));
    tbl.push_back(mk(1,1, 0,0, 0,0, 5,1, 0,0,  1,0,0,0,0));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 0,0,  0,0,0,0,0));
    // WAW saturation on r7
    tbl.push_back(mk(0,1, 0,0, 0,0, 7,1, 0,0,  0,1,1,0,0));
    tbl.push_back(mk(0,1, 0,0, 0,0, 7,1, 0,0,  0,1,2,0,0));
    tbl.push_back(mk(0,1, 0,0, 0,0, 7,1, 0,0,  0,1,3,0,0));
    tbl.push_back(mk(0,1, 0,0, 0,0, 7,1, 1,7,  1,0,2,0,0));
    tbl.push_back(mk(0,1, 0,0, 0,0, 7,1, 0,0,  0,1,3,0,0));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 1,7,  0,0,2,0,0));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 1,7,  0,0,1,0,0));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 1,7,  0,0,0,0,0));
    // capacity
    tbl.push_back(mk(0,1, 0,0, 0,0, 1,1, 0,0,  0,1,1,0,0));
    tbl.push_back(mk(0,1, 0,0, 0,0, 2,1, 0,0,  0,1,2,0,0));
    tbl.push_back(mk(0,1, 0,0, 0,0, 3,1, 0,0,  0,1,3,0,0));
    tbl.push_back(mk(0,1, 0,0, 0,0, 4,1, 0,0,  0,1,4,0,0));
    tbl.push_back(mk(0,1, 0,0, 0,0, 6,1, 0,0,  1,0,4,0,0));
    tbl.push_back(mk(0,1, 0,0, 0,0, 6,1, 1,2,  0,1,4,0,0));
    tbl.push_back(mk(0,1, 0,0, 0,0, 9,1, 0,0,  1,0,4,0,0));
    // r0 never counted or stalled, WB r0 never flags
    tbl.push_back(mk(0,1, 0,0, 0,0, 0,1, 0,0,  0,1,4,0,0));
    tbl.push_back(mk(0,1, 0,1, 0,1, 0,1, 1,0,  0,1,4,0,0));
    // source hazards
    tbl.push_back(mk(0,1, 0,0, 1,1, 0,0, 0,0,  1,0,4,0,0));
    tbl.push_back(mk(0,1, 2,1, 0,0, 0,0, 0,0,  0,1,4,0,0));
    // simultaneous issue + WB on r3 at full capacity
    tbl.push_back(mk(0,1, 0,0, 0,0, 3,1, 1,3,  0,1,4,0,0));
    tbl.push_back(mk(0,1, 3,1, 0,0, 0,0, 0,0,  1,0,4,0,0));
    // drain
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 1,1,  0,0,3,0,0));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 1,3,  0,0,2,0,0));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 1,4,  0,0,1,0,0));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 1,6,  0,0,0,0,0));
    // sticky error
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 1,9,  0,0,0,1,0));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 1,3,  0,0,0,1,0));
    tbl.push_back(mk(0,1, 0,0, 0,0, 9,1, 0,0,  0,1,1,1,0));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 1,9,  0,0,0,1,0));
    // reset mid-operation discards tracking
    tbl.push_back(mk(0,1, 0,0, 0,0,10,1, 0,0,  0,1,1,1,0));
    tbl.push_back(mk(1,0, 0,0, 0,0, 0,0, 0,0,  1,0,0,0,0));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 1,10, 0,0,0,1,0));
    tbl.push_back(mk(1,0, 0,0, 0,0, 0,0, 0,0,  1,0,0,0,0));
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 0,0,  0,0,0,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], i);
    end

    // RAW on r5: WB in the fourth cycle of the sequence
    apply(mk(0,1, 0,0, 0,0, 5,1, 0,0, 0,1,1,0,0), 100);
    apply(mk(0,1, 5,1, 0,0, 0,0, 0,0, 1,0,1,0,0), 101);
    apply(mk(0,1, 5,1, 0,0, 0,0, 0,0, 1,0,1,0,0), 102);
    apply(mk(0,1, 5,1, 0,0, 0,0, 1,5, !BYP,BYP,0,0,BYP), 103);
    if (BYP)
      apply(mk(0,0, 0,0, 0,0, 0,0, 0,0, 0,0,0,0,0), 104);
    else
      apply(mk(0,1, 5,1, 0,0, 0,0, 0,0, 0,1,0,0,0), 104);
    apply(mk(0,0, 0,0, 0,0, 0,0, 0,0, 0,0,0,0,0), 105);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
